// File: rtl/ser_pkg.sv
//==============================================================================
// Module      : ser_pkg
// Description : Shared definitions for the PISO bit serializer: FSM state
//               encoding, frame-length derivation and counter-width helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ser_pkg;

   // Two-state serializer FSM encoding.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Number of serial bits per frame: data bits plus an optional parity bit.
   function automatic int frame_len(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

   // Bits needed to hold a down-counter starting at len-1; never below 1.
   function automatic int cnt_width(input int len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

endpackage

`default_nettype wire

// File: rtl/piso_bit_serializer.sv
//==============================================================================
// Module      : piso_bit_serializer
// Description : Parallel-in / serial-out stage. Accepts a WIDTH-bit word over a
//               valid/ready handshake and emits it one bit per clock on dout,
//               with dout forced to 0 between frames. Back-to-back frames are
//               supported with no idle bubble.
//               Optional macro SER_PARITY_EN appends an even-parity bit
//               (XOR of the accepted word) after the data bits.
// Ports       : clk         - system clock (rising edge)
//               rst         - synchronous active-high reset
//               data_in     - parallel word, sampled on the handshake edge
//               load_valid  - upstream word available
//               load_ready  - serializer can accept a word (combinational)
//               dout        - serial data bit (registered)
//               dout_valid  - dout carries a frame bit (registered)
//               frame_done  - pulse on the final bit of a frame (registered)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_done
);

`ifdef SER_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
   localparam int CNT_W     = cnt_width(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_dout;
   logic              r_dout_valid;
   logic              r_frame_done;

   logic              w_cnt_zero;
   logic              w_load_ready;
   logic              w_accept;
   logic              w_advance;
   logic              w_load_first;
   logic [WIDTH-1:0]  w_load_rest;
   logic              w_shift_out;
   logic [WIDTH-1:0]  w_shift_nxt;
   logic              w_next_bit;

   assign w_cnt_zero = (r_cnt == CNT_ZERO);

   //---------------------------------------------------------------------------
   // Bit ordering. The first bit of a word goes straight from data_in to dout
   // on the handshake edge; the shift register keeps only the remaining bits.
   //---------------------------------------------------------------------------
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_load_first = data_in[WIDTH-1];
         assign w_load_rest  = {data_in[WIDTH-2:0], 1'b0};
         assign w_shift_out  = r_shift[WIDTH-1];
         assign w_shift_nxt  = {r_shift[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_load_first = data_in[0];
         assign w_load_rest  = {1'b0, data_in[WIDTH-1:1]};
         assign w_shift_out  = r_shift[0];
         assign w_shift_nxt  = {1'b0, r_shift[WIDTH-1:1]};
      end
   endgenerate

`ifdef SER_PARITY_EN
   logic r_parity;

   // Counter at 1 means the bit about to be emitted is the frame's last one,
   // which is the parity bit when it is enabled.
   assign w_next_bit = (r_cnt == CNT_ONE) ? r_parity : w_shift_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^data_in;
      end
   end
`else
   assign w_next_bit = w_shift_out;
`endif

   //---------------------------------------------------------------------------
   // FSM: next-state and handshake decode.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_load_ready = 1'b0;
      w_advance    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_load_ready = 1'b1;
         end
         ST_SHIFT: begin
            // Ready again on the last bit so the next word follows seamlessly.
            w_load_ready = w_cnt_zero;
            w_advance    = !w_cnt_zero;
            if (w_cnt_zero) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (rst) begin
         w_load_ready = 1'b0;
      end

      w_accept = w_load_ready && load_valid;
      if (w_accept) begin
         w_state_nxt = ST_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Datapath: shift register, bit counter and registered outputs.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift      <= '0;
         r_cnt        <= CNT_ZERO;
         r_dout       <= 1'b0;
         r_dout_valid <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (w_accept) begin
         r_shift      <= w_load_rest;
         r_cnt        <= CNT_START;
         r_dout       <= w_load_first;
         r_dout_valid <= 1'b1;
         r_frame_done <= 1'b0;
      end else if (w_advance) begin
         r_shift      <= w_shift_nxt;
         r_cnt        <= r_cnt - CNT_ONE;
         r_dout       <= w_next_bit;
         r_dout_valid <= 1'b1;
         r_frame_done <= (r_cnt == CNT_ONE);
      end else begin
         // No frame active: keep dout low so the downstream detector idles.
         r_dout       <= 1'b0;
         r_dout_valid <= 1'b0;
         r_frame_done <= 1'b0;
      end
   end

   assign load_ready = w_load_ready;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_piso_bit_serializer.sv
//==============================================================================
// Module      : tb_piso_bit_serializer
// Description : Directed self-checking bench for piso_bit_serializer. Drives an
//               MSB-first and an LSB-first instance; expectations follow the
//               SER_PARITY_EN macro when it is defined for the build.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_piso_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       valid_m;
   logic       valid_l;
   logic       ready_m, dout_m, dv_m, done_m;
   logic       ready_l, dout_l, dv_l, done_l;

   int vectors;
   int errors;

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load_valid (valid_m),
      .load_ready (ready_m),
      .dout       (dout_m),
      .dout_valid (dv_m),
      .frame_done (done_m)
   );

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load_valid (valid_l),
      .load_ready (ready_l),
      .dout       (dout_l),
      .dout_valid (dv_l),
      .frame_done (done_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected j-th serial bit of a frame for a given word and bit order.
   function automatic logic exp_bit(input logic [7:0] w, input int j, input bit msb);
      if (j >= 8) return ^w;
      return msb ? w[7-j] : w[j];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      valid_m = 1'b0;
      valid_l = 1'b0;
      data_in = 8'h00;
      repeat (3) tick();
      vectors++;
      if ({dout_m, dv_m, done_m, ready_m} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_msb: got dout/dv/done/ready=%b expected 0000",
                  {dout_m, dv_m, done_m, ready_m});
      end
      vectors++;
      if ({dout_l, dv_l, done_l, ready_l} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_lsb: got dout/dv/done/ready=%b expected 0000",
                  {dout_l, dv_l, done_l, ready_l});
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (ready_m !== 1'b1 || ready_l !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got msb=%b lsb=%b expected 1 1", ready_m, ready_l);
      end
   endtask

   // Sends one word to the selected instance and checks every frame cycle
   // plus the idle cycle afterwards.
   task automatic send_frame(input string name, input logic [7:0] w, input bit msb);
      logic d, v, f, r;
      data_in = w;
      if (msb) valid_m = 1'b1; else valid_l = 1'b1;
      #1;
      r = msb ? ready_m : ready_l;
      vectors++;
      if (r !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_ready: got %b expected 1", name, r);
      end
      tick();
      valid_m = 1'b0;
      valid_l = 1'b0;
      data_in = ~w;  // data_in is free to change after the handshake
      for (int j = 0; j < FL; j++) begin
         d = msb ? dout_m  : dout_l;
         v = msb ? dv_m    : dv_l;
         f = msb ? done_m  : done_l;
         r = msb ? ready_m : ready_l;
         vectors++;
         if (d !== exp_bit(w, j, msb) || v !== 1'b1) begin
            errors++;
            $display("FAIL %s bit%0d: got dout=%b dv=%b expected dout=%b dv=1",
                     name, j, d, v, exp_bit(w, j, msb));
         end
         vectors++;
         if (f !== (j == FL-1) || r !== (j == FL-1)) begin
            errors++;
            $display("FAIL %s ctl%0d: got done=%b ready=%b expected %b %b",
                     name, j, f, r, (j == FL-1), (j == FL-1));
         end
         tick();
      end
      d = msb ? dout_m  : dout_l;
      v = msb ? dv_m    : dv_l;
      f = msb ? done_m  : done_l;
      r = msb ? ready_m : ready_l;
      vectors++;
      if ({d, v, f, r} !== 4'b0001) begin
         errors++;
         $display("FAIL %s after_frame: got dout/dv/done/ready=%b expected 0001",
                  name, {d, v, f, r});
      end
   endtask

   task automatic test_basic();
      send_frame("basic_A5", 8'hA5, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      data_in = 8'hFF;
      valid_m = 1'b1;
      tick();
      data_in = 8'h0F;
      for (int j = 0; j < 2*FL; j++) begin
         w = (j < FL) ? 8'hFF : 8'h0F;
         if (j == FL) valid_m = 1'b0;
         vectors++;
         if (dout_m !== exp_bit(w, j % FL, 1'b1) || dv_m !== 1'b1) begin
            errors++;
            $display("FAIL b2b bit%0d: got dout=%b dv=%b expected dout=%b dv=1",
                     j, dout_m, dv_m, exp_bit(w, j % FL, 1'b1));
         end
         vectors++;
         if (done_m !== ((j % FL) == FL-1) || ready_m !== ((j % FL) == FL-1)) begin
            errors++;
            $display("FAIL b2b ctl%0d: got done=%b ready=%b expected %b %b",
                     j, done_m, ready_m, ((j % FL) == FL-1), ((j % FL) == FL-1));
         end
         tick();
      end
      vectors++;
      if ({dout_m, dv_m, done_m, ready_m} !== 4'b0001) begin
         errors++;
         $display("FAIL b2b after: got dout/dv/done/ready=%b expected 0001",
                  {dout_m, dv_m, done_m, ready_m});
      end
   endtask

   task automatic test_reset_mid_frame();
      data_in = 8'hC3;
      valid_m = 1'b1;
      tick();
      valid_m = 1'b0;
      for (int j = 0; j < 3; j++) begin
         vectors++;
         if (dout_m !== exp_bit(8'hC3, j, 1'b1) || dv_m !== 1'b1) begin
            errors++;
            $display("FAIL midrst bit%0d: got dout=%b dv=%b expected dout=%b dv=1",
                     j, dout_m, dv_m, exp_bit(8'hC3, j, 1'b1));
         end
         if (j < 2) tick();
      end
      // Abort, and offer a word during reset which must be ignored.
      rst     = 1'b1;
      data_in = 8'hFF;
      valid_m = 1'b1;
      #1;
      vectors++;
      if (ready_m !== 1'b0) begin
         errors++;
         $display("FAIL midrst ready_in_rst: got %b expected 0", ready_m);
      end
      tick();
      vectors++;
      if ({dout_m, dv_m, done_m} !== 3'b000) begin
         errors++;
         $display("FAIL midrst abort: got dout/dv/done=%b expected 000", {dout_m, dv_m, done_m});
      end
      valid_m = 1'b0;
      rst     = 1'b0;
      #1;
      vectors++;
      if (ready_m !== 1'b1) begin
         errors++;
         $display("FAIL midrst ready_after: got %b expected 1", ready_m);
      end
      tick();
      vectors++;
      if ({dout_m, dv_m, done_m} !== 3'b000) begin
         errors++;
         $display("FAIL midrst no_residue: got dout/dv/done=%b expected 000", {dout_m, dv_m, done_m});
      end
      send_frame("post_rst_81", 8'h81, 1'b1);
   endtask

   task automatic test_lsb_first();
      send_frame("lsb_01", 8'h01, 1'b0);
      send_frame("lsb_B4", 8'hB4, 1'b0);
   endtask

   task automatic test_parity_words();
      send_frame("par_07", 8'h07, 1'b1);
      send_frame("par_03", 8'h03, 1'b1);
   endtask

   task automatic test_pattern_F0();
      send_frame("pat_F0", 8'hF0, 1'b1);
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_mid_frame();
      test_lsb_first();
      test_parity_words();
      test_pattern_F0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial pattern-detector FSM and drives its `din` input.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `dout`.
- `dout` is held at 0 whenever no frame is active, so the downstream detector sees no spurious 1s between frames.
- Supports back-to-back frames with no idle bubble between them.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, bit order: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  parallel word; sampled on the handshake cycle.
- load_valid  in  1  upstream has a word on data_in.
- load_ready  out  1  serializer can accept a word this cycle.
- dout  out  1  serial data bit; connects to the detector's din.
- dout_valid  out  1  dout carries a frame bit this cycle.
- frame_done  out  1  one-cycle pulse coinciding with the last bit of a frame.

Behaviour:
- Handshake: a word is accepted when load_valid && load_ready is high at a rising edge of clk. data_in may change freely at any other time.
- State machine has two states:
  - IDLE: load_ready=1. On a handshake, load the shift register, set the bit counter to FRAME_LEN-1, go to SHIFT.
  - SHIFT: each cycle, advance the shift register by one bit and decrement the counter.
  - When counter==0 (last bit), load_ready=1. On a handshake that cycle, reload and stay in SHIFT (back-to-back). With no handshake, go to IDLE.
- FRAME_LEN = WIDTH, or WIDTH+1 when the optional feature is enabled. Counter width is $clog2(FRAME_LEN).
- Outputs:
  - dout, dout_valid and frame_done are registered.
  - load_ready is combinational from state and counter, and is forced to 0 while rst=1.
- Latency: for a handshake at edge k, the first bit appears on dout after edge k. Bits occupy edges k .. k+FRAME_LEN-1.
- dout_valid=1 for exactly FRAME_LEN consecutive cycles per frame. frame_done=1 only in the final cycle.
- Whenever dout_valid=0, dout=0.
- Reset values: state=IDLE, shift register=0, counter=0, dout=0, dout_valid=0, frame_done=0.
- Reset mid-frame: the frame is aborted with no residual bits. Outputs are 0 from the edge where rst is sampled high. load_ready=1 in the first cycle after rst falls.
- A handshake presented while rst=1 is ignored; no word is accepted.
- In SHIFT with counter!=0, load_valid is ignored because load_ready=0, and the word is not lost upstream.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined: after the WIDTH data bits, one extra bit is appended with dout_valid=1. It equals the XOR reduction of the accepted word (even parity). FRAME_LEN=WIDTH+1, and frame_done pulses on the parity bit.
- When undefined: there is no parity logic, FRAME_LEN=WIDTH, and frame_done pulses on the last data bit.

Decomposition:
- Shared package (ser_pkg) holds:
  - state encoding constants: ST_IDLE=0, ST_SHIFT=1.
  - the FRAME_LEN derivation function.
  - the counter-width helper.
- No sub-module is needed. The shift register, counter and FSM fit in a single module.
- The downstream detector is instantiated only in the system-level bench, not inside this block.

Test Plan:
1. Reset 3 cycles, then load 8'hA5 with MSB_FIRST=1 -> dout sequence 1,0,1,0,0,1,0,1; dout_valid high 8 cycles; frame_done high on the 8th; dout=0 afterwards.
2. load_valid held high with 8'hFF then 8'h0F back-to-back -> 16 contiguous dout_valid cycles with no bubble; load_ready high only in IDLE and on counter==0 cycles; two frame_done pulses 8 cycles apart.
3. Assert rst for 1 cycle after the 3rd bit of 8'hC3 -> dout/dout_valid go 0 at that edge with no further bits; load_ready=1 the cycle after rst falls; the next word 8'h81 serializes cleanly.
4. MSB_FIRST=0, load 8'h01 -> first dout bit is 1, followed by seven 0s.
5. SER_PARITY_EN defined, load 8'h07 -> 9 valid bits, 9th bit=1; then load 8'h03 -> 9th bit=0; frame_done on the 9th bit each time.
6. System bench with the detector on dout, load 8'hF0 -> the detector's dout pulses high on the 2nd and 4th serialized 1s.
